// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter for a single req/gnt/rvalid memory port.
// Holds the winner until granted and routes in-order responses via an ID queue.
module mem_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter bit DATA_PRIO       = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 instr_req_i,
  input  logic [31:0]                          instr_addr_i,
  output logic                                 instr_gnt_o,
  output logic                                 instr_rvalid_o,
  output logic [31:0]                          instr_rdata_o,
  output logic                                 instr_err_o,
  input  logic                                 data_req_i,
  input  logic                                 data_we_i,
  input  logic [3:0]                           data_be_i,
  input  logic [31:0]                          data_addr_i,
  input  logic [31:0]                          data_wdata_i,
  output logic                                 data_gnt_o,
  output logic                                 data_rvalid_o,
  output logic [31:0]                          data_rdata_o,
  output logic                                 data_err_o,
  output logic                                 mem_req_o,
  output logic                                 mem_we_o,
  output logic [3:0]                           mem_be_o,
  output logic [31:0]                          mem_addr_o,
  output logic [31:0]                          mem_wdata_o,
  input  logic                                 mem_gnt_i,
  input  logic                                 mem_rvalid_i,
  input  logic [31:0]                          mem_rdata_i,
  input  logic                                 mem_err_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 protocol_err_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;

  state_t          state_q, state_d;
  logic            owner;          // 1 = data port, 0 = fetch port
  logic            owner_req;
  logic            last_owner_q;
  logic            grant, pop, full, empty, head;
  logic            id_q [MAX_OUTSTANDING];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CW'(MAX_OUTSTANDING));
  assign empty = (count_q == '0);
  assign head  = id_q[rd_ptr_q];

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    owner   = 1'b0;
    state_d = IDLE;
    case (state_q)
      HOLD_I:  owner = 1'b0;
      HOLD_D:  owner = 1'b1;
      default: begin
        if (DATA_PRIO || !(instr_req_i && data_req_i)) owner = data_req_i;
        else                                           owner = ~last_owner_q;
      end
    endcase
    owner_req = owner ? data_req_i : instr_req_i;
    mem_req_o = owner_req & ~full & ~rst;
    grant     = mem_req_o & mem_gnt_i;
    if (mem_req_o && !mem_gnt_i) state_d = owner ? HOLD_D : HOLD_I;
  end

  assign mem_we_o    = owner ? data_we_i    : 1'b0;
  assign mem_be_o    = owner ? data_be_i    : 4'hF;
  assign mem_addr_o  = owner ? data_addr_i  : instr_addr_i;
  assign mem_wdata_o = owner ? data_wdata_i : 32'h0;

  assign instr_gnt_o = grant & ~owner;
  assign data_gnt_o  = grant &  owner;

  // A response without a queued ID is a protocol error and is not routed anywhere.
  assign pop            = mem_rvalid_i & ~empty & ~rst;
  assign instr_rvalid_o = pop & ~head;
  assign data_rvalid_o  = pop &  head;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign instr_err_o    = mem_err_i;
  assign data_err_o     = mem_err_i;
  assign outstanding_o  = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      last_owner_q   <= 1'b1;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      protocol_err_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        wr_ptr_q     <= next_ptr(wr_ptr_q);
        last_owner_q <= owner;
      end
      if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({grant, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (mem_rvalid_i && empty) protocol_err_o <= 1'b1;
    end
  end

  // NOTE: the ID storage is deliberately not reset; count_q gates every read of it.
  always_ff @(posedge clk) begin
    if (!rst && grant) id_q[wr_ptr_q] <= owner;
  end

endmodule
